// File: rtl/proppy_megabytebeat_pkg.sv
// Shared constants for the bytebeat tile: formula selects, default sizing,
// ui_in/uio_out bit positions and a small 8-bit multiply helper.
package megabytebeat_pkg;

  localparam int DIV_DEFAULT     = 1250;
  localparam int T_WIDTH_DEFAULT = 24;

  localparam logic [2:0] F_SAW     = 3'd0;
  localparam logic [2:0] F_CRYSTAL = 3'd1;
  localparam logic [2:0] F_CHIME   = 3'd2;
  localparam logic [2:0] F_SLIDE   = 3'd3;
  localparam logic [2:0] F_MELODY  = 3'd4;
  localparam logic [2:0] F_SPARSE  = 3'd5;
  localparam logic [2:0] F_AND     = 3'd6;
  localparam logic [2:0] F_XOR     = 3'd7;

  localparam int UI_SEL_LSB   = 0;
  localparam int UI_SEL_MSB   = 2;
  localparam int UI_PAUSE     = 3;
  localparam int UI_INVERT    = 4;
  localparam int UI_SPEED_LSB = 5;
  localparam int UI_SPEED_MSB = 7;

  localparam int UIO_PWM    = 0;
  localparam int UIO_STROBE = 1;

  // Product modulo 256; only the low operand bytes can reach the result.
  function automatic logic [7:0] mul8(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = {8'd0, a} * {8'd0, b};
    return p[7:0];
  endfunction

endpackage

// File: rtl/proppy_megabytebeat_if.sv
// TinyTapeout user-pin bundle; the harness side is master, the tile is slave.
interface proppy_megabytebeat_if;
  import megabytebeat_pkg::*;

  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (
    output ena,
    output ui_in,
    output uio_in,
    input  uo_out,
    input  uio_out,
    input  uio_oe
  );

  modport slave (
    input  ena,
    input  ui_in,
    input  uio_in,
    output uo_out,
    output uio_out,
    output uio_oe
  );

endinterface

// File: rtl/proppy_megabytebeat_formula.sv
// Combinational bytebeat formula bank: maps time t to an 8-bit sample.
// Every term is reduced to its low byte since all results are taken mod 256.
module bytebeat_formula
  import megabytebeat_pkg::*;
#(
  parameter int T_WIDTH = T_WIDTH_DEFAULT
) (
  input  logic [T_WIDTH-1:0] t,
  input  logic [2:0]         sel,
  output logic [7:0]         sample
);

  // Logical shift on the full-width t, keeping the low byte.
  function automatic logic [7:0] shr8(input logic [T_WIDTH-1:0] v, input int unsigned n);
    logic [T_WIDTH-1:0] w;
    w = v >> n;
    return w[7:0];
  endfunction

  logic [7:0] t0_s, t4_s, t5_s, t6_s, t7_s, t8_s, t9_s, t10_s, t12_s, t13_s;

  assign t0_s  = t[7:0];
  assign t4_s  = shr8(t, 4);
  assign t5_s  = shr8(t, 5);
  assign t6_s  = shr8(t, 6);
  assign t7_s  = shr8(t, 7);
  assign t8_s  = shr8(t, 8);
  assign t9_s  = shr8(t, 9);
  assign t10_s = shr8(t, 10);
  assign t12_s = shr8(t, 12);
  assign t13_s = shr8(t, 13);

  always_comb begin
    sample = 8'd0;
    case (sel)
      F_SAW:     sample = t0_s;
      F_CRYSTAL: sample = mul8(t0_s, (t12_s | t8_s) & 8'd63 & t4_s);
      F_CHIME:   sample = (mul8(t0_s, 8'd5) & t7_s) | (mul8(t0_s, 8'd3) & t10_s);
      F_SLIDE:   sample = mul8(t0_s, t5_s | t8_s);
      F_MELODY:  sample = mul8(t0_s, 8'd42 & t10_s);
      F_SPARSE:  sample = mul8(t0_s, (t9_s | t13_s) & 8'd25 & t6_s);
      F_AND:     sample = t0_s & t8_s;
      F_XOR:     sample = t0_s ^ t8_s;
      default:   sample = t0_s;
    endcase
  end

endmodule

// File: rtl/proppy_megabytebeat.sv
// Bytebeat tile top: sample-rate divider, time counter, registered sample,
// advance strobe and an 8-bit PWM audio output.
module proppy_megabytebeat
  import megabytebeat_pkg::*;
#(
  parameter int DIV     = DIV_DEFAULT,
  parameter int T_WIDTH = T_WIDTH_DEFAULT
) (
  input logic             clk,
  input logic             rst,
  proppy_megabytebeat_if.slave tt
);

  localparam int                 DW       = $clog2(DIV);
  localparam logic [DW-1:0]      DIV_LAST = DW'(DIV - 1);
  localparam logic [DW-1:0]      DIV_ONE  = DW'(1);
  localparam logic [T_WIDTH-1:0] T_ONE    = T_WIDTH'(1);

  logic [DW-1:0]      div_cnt_q, div_cnt_d;
  logic [T_WIDTH-1:0] t_q, t_d;
  logic               adv_q, adv_d;
  logic               strobe_q, strobe_d;
  logic [7:0]         sample_q, sample_d;
  logic [7:0]         pwm_cnt_q, pwm_cnt_d;
  logic               pwm_q, pwm_d;

  logic               tick_s;
  logic [2:0]         speed_s;
  logic [T_WIDTH-1:0] step_s;
  logic [7:0]         formula_s;
  logic               unused_s;

  bytebeat_formula #(.T_WIDTH(T_WIDTH)) u_formula (
    .t      (t_q),
    .sel    (tt.ui_in[UI_SEL_MSB:UI_SEL_LSB]),
    .sample (formula_s)
  );

  // Next-state logic. The divider free-runs; only the t advance is gated.
  always_comb begin
    tick_s  = (div_cnt_q == DIV_LAST);
    speed_s = tt.ui_in[UI_SPEED_MSB:UI_SPEED_LSB];
    step_s  = T_ONE << speed_s;

    if (tick_s) begin
      div_cnt_d = '0;
    end else begin
      div_cnt_d = div_cnt_q + DIV_ONE;
    end

    adv_d = tick_s & tt.ena & ~tt.ui_in[UI_PAUSE];
    if (adv_d) begin
      t_d = t_q + step_s;
    end else begin
      t_d = t_q;
    end

    // adv_q marks the cycle t changed; one more cycle lines up with the new sample.
    strobe_d  = adv_q;
    sample_d  = formula_s ^ {8{tt.ui_in[UI_INVERT]}};
    pwm_cnt_d = pwm_cnt_q + 8'd1;
    pwm_d     = (pwm_cnt_q < sample_q);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q <= '0;
      t_q       <= '0;
      adv_q     <= 1'b0;
      strobe_q  <= 1'b0;
      sample_q  <= 8'd0;
      pwm_cnt_q <= 8'd0;
      pwm_q     <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      t_q       <= t_d;
      adv_q     <= adv_d;
      strobe_q  <= strobe_d;
      sample_q  <= sample_d;
      pwm_cnt_q <= pwm_cnt_d;
      pwm_q     <= pwm_d;
    end
  end

  assign unused_s   = ^tt.uio_in;
  assign tt.uo_out  = sample_q;
  assign tt.uio_out = {6'd0, strobe_q, pwm_q};
  assign tt.uio_oe  = 8'hFF;

endmodule

// File: tb/tb_proppy_megabytebeat.sv
// Directed bench for proppy_megabytebeat (DIV=4) with hand-computed vectors;
// a 16-bit-t instance covers counter wrap, a bare formula instance covers the formula bank.
module tb_proppy_megabytebeat;
  import megabytebeat_pkg::*;

  typedef struct {
    logic [7:0] ui;
    logic       ena;
    int         ncyc;
    logic [7:0] exp_uo;
    logic       exp_st;
    int         exp_ns;
  } vec_t;

  typedef struct {
    logic [23:0] t;
    logic [2:0]  sel;
    logic [7:0]  want;
  } fvec_t;

  logic clk = 1'b0;
  logic rst;
  logic rst2;
  always #5 clk = ~clk;

  proppy_megabytebeat_if bus ();
  proppy_megabytebeat_if bus2 ();

  proppy_megabytebeat #(.DIV(4), .T_WIDTH(24)) dut (.clk(clk), .rst(rst), .tt(bus));
  proppy_megabytebeat #(.DIV(4), .T_WIDTH(16)) dut2 (.clk(clk), .rst(rst2), .tt(bus2));

  logic [23:0] ft;
  logic [2:0]  fsel;
  logic [7:0]  fsample;
  bytebeat_formula #(.T_WIDTH(24)) u_fx (.t(ft), .sel(fsel), .sample(fsample));

  int nvec = 0;
  int nmis = 0;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] want);
    nvec++;
    if (act !== want) begin
      nmis++;
      $display("FAIL %s: got %0d, want %0d", name, act, want);
    end
  endtask

  task automatic checki(input string name, input int act, input int want);
    nvec++;
    if (act != want) begin
      nmis++;
      $display("FAIL %s: got %0d, want %0d", name, act, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic count_pwm(input int n, output int highs);
    highs = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (bus.uio_out[UIO_PWM]) highs++;
    end
  endtask

  vec_t  vt [28];
  fvec_t fv [16];

  initial begin
    int ns;
    int hi_bad;
    int highs;

    vt[0]  = '{8'h00, 1'b1, 4,  8'd0,   1'b0, 0};
    vt[1]  = '{8'h00, 1'b1, 1,  8'd1,   1'b1, 1};
    vt[2]  = '{8'h00, 1'b1, 1,  8'd1,   1'b0, 0};
    vt[3]  = '{8'h00, 1'b1, 3,  8'd2,   1'b1, 1};
    vt[4]  = '{8'h00, 1'b1, 4,  8'd3,   1'b1, 1};
    vt[5]  = '{8'h00, 1'b1, 8,  8'd5,   1'b1, 2};
    vt[6]  = '{8'h18, 1'b1, 1,  8'd250, 1'b0, 0};
    vt[7]  = '{8'h08, 1'b1, 1,  8'd5,   1'b0, 0};
    vt[8]  = '{8'h08, 1'b1, 20, 8'd5,   1'b0, 0};
    vt[9]  = '{8'h00, 1'b1, 2,  8'd6,   1'b1, 1};
    vt[10] = '{8'h00, 1'b0, 20, 8'd6,   1'b0, 0};
    vt[11] = '{8'h00, 1'b1, 2,  8'd6,   1'b0, 0};
    vt[12] = '{8'h08, 1'b1, 1,  8'd6,   1'b0, 0};
    vt[13] = '{8'h00, 1'b1, 1,  8'd6,   1'b0, 0};
    vt[14] = '{8'h00, 1'b1, 4,  8'd7,   1'b1, 1};
    vt[15] = '{8'h06, 1'b1, 1,  8'd0,   1'b0, 0};
    vt[16] = '{8'h07, 1'b1, 1,  8'd7,   1'b0, 0};
    vt[17] = '{8'h60, 1'b1, 2,  8'd15,  1'b1, 1};
    vt[18] = '{8'h60, 1'b1, 4,  8'd23,  1'b1, 1};
    vt[19] = '{8'h63, 1'b1, 4,  8'd0,   1'b1, 1};
    vt[20] = '{8'h43, 1'b1, 4,  8'd35,  1'b1, 1};
    vt[21] = '{8'h23, 1'b1, 4,  8'd37,  1'b1, 1};
    vt[22] = '{8'hA3, 1'b1, 4,  8'd138, 1'b1, 1};
    vt[23] = '{8'h83, 1'b1, 4,  8'd170, 1'b1, 1};
    vt[24] = '{8'h63, 1'b1, 4,  8'd186, 1'b1, 1};
    vt[25] = '{8'h43, 1'b1, 4,  8'd35,  1'b1, 1};
    vt[26] = '{8'h23, 1'b1, 4,  8'd41,  1'b1, 1};
    vt[27] = '{8'h03, 1'b1, 4,  8'd44,  1'b1, 1};

    fv[0]  = '{24'h000025, 3'd3, 8'd37};
    fv[1]  = '{24'h000064, 3'd3, 8'd44};
    fv[2]  = '{24'h000303, 3'd6, 8'd3};
    fv[3]  = '{24'h000303, 3'd2, 8'd6};
    fv[4]  = '{24'h001234, 3'd0, 8'd52};
    fv[5]  = '{24'h001234, 3'd1, 8'd156};
    fv[6]  = '{24'h001234, 3'd2, 8'd4};
    fv[7]  = '{24'h001234, 3'd3, 8'd220};
    fv[8]  = '{24'h001234, 3'd5, 8'd160};
    fv[9]  = '{24'h001234, 3'd6, 8'd16};
    fv[10] = '{24'h001234, 3'd7, 8'd38};
    fv[11] = '{24'h002C05, 3'd4, 8'd50};
    fv[12] = '{24'hABCDEF, 3'd1, 8'd36};
    fv[13] = '{24'hABCDEF, 3'd3, 8'd33};
    fv[14] = '{24'hABCDEF, 3'd6, 8'd205};
    fv[15] = '{24'hABCDEF, 3'd7, 8'd34};

    rst = 1'b1;
    rst2 = 1'b1;
    bus.ena = 1'b1;
    bus.ui_in = 8'h00;
    bus.uio_in = 8'hA5;
    bus2.ena = 1'b1;
    bus2.ui_in = 8'hE0;
    bus2.uio_in = 8'h5A;
    ft = 24'd0;
    fsel = 3'd0;

    step();
    step();
    step();
    check8("reset_uo_out", bus.uo_out, 8'h00);
    check8("reset_uio_out", bus.uio_out, 8'h00);
    check8("uio_oe", bus.uio_oe, 8'hFF);

    // Main table: edges are counted from the first edge after rst drops.
    rst = 1'b0;
    hi_bad = 0;
    for (int i = 0; i < 28; i++) begin
      bus.ui_in = vt[i].ui;
      bus.ena = vt[i].ena;
      ns = 0;
      for (int c = 0; c < vt[i].ncyc; c++) begin
        step();
        if (bus.uio_out[UIO_STROBE]) ns++;
        if (bus.uio_out[7:2] != 6'd0) hi_bad++;
      end
      nvec++;
      if (bus.uo_out !== vt[i].exp_uo || bus.uio_out[UIO_STROBE] !== vt[i].exp_st || ns != vt[i].exp_ns) begin
        nmis++;
        $display("FAIL vec%0d: uo=%0d strobe=%0d strobes=%0d, want uo=%0d strobe=%0d strobes=%0d",
                 i, bus.uo_out, bus.uio_out[UIO_STROBE], ns, vt[i].exp_uo, vt[i].exp_st, vt[i].exp_ns);
      end
    end
    checki("uio_out_hi_zero", hi_bad, 0);

    for (int i = 0; i < 16; i++) begin
      ft = fv[i].t;
      fsel = fv[i].sel;
      #1;
      nvec++;
      if (fsample !== fv[i].want) begin
        nmis++;
        $display("FAIL formula%0d t=%h sel=%0d: got %0d, want %0d", i, fv[i].t, fv[i].sel, fsample, fv[i].want);
      end
    end

    // Sample 255 (t=0 inverted, paused): 255 high cycles per 256.
    rst = 1'b1;
    bus.ui_in = 8'h18;
    bus.ena = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
    step();
    count_pwm(256, highs);
    checki("pwm_255", highs, 255);

    // Sample 0: never high.
    bus.ui_in = 8'h08;
    step();
    step();
    count_pwm(256, highs);
    checki("pwm_0", highs, 0);

    // Reset in the middle of a running, non-zero output.
    bus.ui_in = 8'h18;
    step();
    step();
    step();
    check8("pre_reset_uo", bus.uo_out, 8'd255);
    rst = 1'b1;
    bus.ui_in = 8'hFF;
    step();
    check8("midrun_reset_uo", bus.uo_out, 8'h00);
    check8("midrun_reset_uio", bus.uio_out, 8'h00);
    check8("midrun_reset_oe", bus.uio_oe, 8'hFF);

    // First tick DIV cycles after release, with s=6 giving t=64, then pause.
    bus.ui_in = 8'hC0;
    rst = 1'b0;
    ns = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (bus.uio_out[UIO_STROBE]) ns++;
    end
    checki("no_strobe_before_first_tick", ns, 0);
    bus.ui_in = 8'h08;
    step();
    check8("first_tick_strobe", {7'd0, bus.uio_out[UIO_STROBE]}, 8'd1);
    check8("first_tick_uo", bus.uo_out, 8'd64);
    step();
    count_pwm(512, highs);
    checki("pwm_64", highs, 128);

    // Wrap on the 16-bit instance: s=7 to 0xFF80, then s=3 to 0xFFF8 and 0.
    rst2 = 1'b0;
    for (int c = 0; c < 2044; c++) step();
    bus2.ui_in = 8'h60;
    step();
    check8("wrap_ff80", bus2.uo_out, 8'd128);
    for (int c = 0; c < 60; c++) step();
    check8("wrap_fff8", bus2.uo_out, 8'd248);
    for (int c = 0; c < 4; c++) step();
    check8("wrap_zero", bus2.uo_out, 8'd0);
    check8("wrap_strobe", {7'd0, bus2.uio_out[UIO_STROBE]}, 8'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/proppy_megabytebeat.md
Name: proppy_megabytebeat

Overview:
- Bytebeat audio generator for a TinyTapeout tile.
- A time counter t advances at a sample rate derived from clk; one of 8 fixed bytebeat formulas maps t to an 8-bit sample.
- The sample drives uo_out in parallel and a 1-bit PWM audio pin on uio_out[0].
- Top-level user block; pads and mux are handled by the TT harness.

Parameters:
- DIV, 1250, clk cycles per sample tick (10 MHz / 1250 = 8 kHz); legal range ≥ 2.
- T_WIDTH, 24, width of the time counter t; minimum 16.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  reset, synchronous, active-high.
- ena  in  1  tile enable; low freezes t exactly like pause.
- ui_in  in  8  [2:0] formula select; [3] pause; [4] invert sample; [7:5] speed exponent s.
- uo_out  out  8  registered 8-bit sample.
- uio_in  in  8  unused; ignored.
- uio_out  out  8  [0] PWM audio; [1] sample strobe; [7:2] = 0.
- uio_oe  out  8  constant 8'hFF.

Behaviour:
- Divider:
  - div_cnt counts 0..DIV-1 and wraps.
  - tick = (div_cnt == DIV-1).
  - div_cnt runs regardless of pause and ena.
- Time counter:
  - On tick, if ena=1 and ui_in[3]=0: t <= t + (1 << s), modulo 2^T_WIDTH, with s = ui_in[7:5].
  - Otherwise t holds.
- Formulas: combinational f(t), all arithmetic truncated to 8 bits (mod 256); shifts are logical on full t.
  - 0: t
  - 1: t*((t>>12 | t>>8) & 63 & (t>>4))
  - 2: (t*5 & t>>7) | (t*3 & t>>10)
  - 3: t*(t>>5 | t>>8)
  - 4: t*(42 & t>>10)
  - 5: t*((t>>9 | t>>13) & 25 & t>>6)
  - 6: t & (t>>8)
  - 7: t ^ (t>>8)
- Sample register:
  - Every cycle, uo_out <= f(t) XOR {8{ui_in[4]}}.
  - Latency is 1 cycle from t (and from a formula or invert change) to uo_out.
- Tick-to-output timing:
  - Tick in cycle k → t new in cycle k+1 → uo_out new in cycle k+2.
  - Strobe uio_out[1] is high exactly during cycle k+2, and only for a tick that advanced t.
- PWM:
  - 8-bit free-running pwm_cnt increments every clk.
  - uio_out[0] is registered: uio_out[0] <= (pwm_cnt < uo_out).
  - Sample 0 → always low; sample 255 → high 255 of every 256 cycles.
- Reset, synchronous and dominant over all other inputs: t=0, div_cnt=0, pwm_cnt=0, uo_out=0, uio_out=0.
- Reset mid-operation: all state returns to the reset values above on the next edge; the first post-reset tick occurs DIV cycles after rst deasserts.
- Boundary cases:
  - Wrap at 2^T_WIDTH-1 → 0 is silent; there is no flag.
  - Changing the formula or invert mid-sample takes effect on uo_out next cycle, without waiting for a tick.
  - Pause asserted on a tick cycle blocks that increment and suppresses its strobe.

Decomposition:
- Package megabytebeat_pkg holds:
  - formula select constants F_SAW..F_XOR (3-bit);
  - DIV and T_WIDTH defaults;
  - ui_in bit-field index constants.
- One sub-module, bytebeat_formula: purely combinational; inputs t[T_WIDTH-1:0] and sel[2:0]; output sample[7:0].
- Divider, counter, sample register, strobe and PWM live in the top.

Test Plan (DIV=4, T_WIDTH=24 unless noted):
- Reset, then formula 0, s=0, ena=1: uo_out steps 0,1,2,3… every 4 cycles; strobe is one cycle wide each step; uio_oe=FF; uio_out[7:2]=0.
- Formula 3 with t driven to 37 and to 100 (run, or force via s): uo_out=37, then 44 (300 mod 256); formula 6 at t=0x0303 gives 3.
- Speed s=3: t sequence 0,8,16…; formula 0 uo_out=0,8,16; wrap from 0xFFFFF8 + 8 → 0 gives uo_out 0.
- Invert: formula 0 at t=5 with ui_in[4]=1 gives uo_out=250; toggling invert changes uo_out within 1 cycle.
- Pause (ui_in[3]=1) or ena=0 for 20 cycles: t and uo_out hold and no strobe; on release, the next tick resumes from the held t.
- PWM: hold the sample at 64 (formula 0, paused at t=64) for 512 cycles: uio_out[0] high exactly 128 cycles; rst asserted mid-run clears all outputs next cycle.
